chnl_pack_arb: RTL and testbench

Packet-level round-robin arbiter that shares one repacker input port (IN chunks per beat, OUT chunks per output word) among N streaming sources in the ML605 channel path. It grants one source for a whole burst of a declared length. After the last data beat it appends zero pad beats until the repacker's chunk count is a multiple of OUT. This keeps every repacker output word from a single source, and it tags the stream with source id and burst end.

---
 rtl/chnl_pack_arb.sv | 149 ++++++++++++++
 tb/tb_chnl_pack_arb.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/chnl_pack_arb.sv
// Packet-level round-robin arbiter feeding a chunk repacker: grants one source per burst
// and appends zero pad beats so every repacker output word comes from a single source.
module chnl_pack_arb #(
    parameter int N   = 4,
    parameter int IN  = 3,
    parameter int OUT = 8,
    parameter int W   = 8,
    parameter int LW  = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req,
    input  logic [N*LW-1:0]        len,
    input  logic [N-1:0]           s_val,
    output logic [N-1:0]           s_rdy,
    input  logic [N*W*IN-1:0]      s_data,
    output logic                   m_val,
    input  logic                   m_rdy,
    output logic [W*IN-1:0]        m_data,
    output logic                   m_last,
    output logic                   m_pad,
    output logic [$clog2(N)-1:0]   grant_id,
    output logic                   busy
);
    localparam int GW = $clog2(N);
    localparam int AW = $clog2(OUT);
    localparam int DW = W * IN;
    localparam logic [AW:0] OUT_V = (AW+1)'(OUT);
    localparam logic [AW:0] INM_V = (AW+1)'(IN % OUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2
    } state_t;

    state_t          state_r, state_nx;
    logic [AW-1:0]   acc_r, acc_nx, acc_step_s;
    logic [LW-1:0]   rem_r, rem_nx;
    logic [GW-1:0]   grant_r, grant_nx;
    logic [GW-1:0]   last_r, last_nx;
    logic            pick_found_s;
    logic [GW-1:0]   pick_idx_s;

    // acc < OUT always holds, so one conditional subtract gives (acc + IN) mod OUT for any OUT.
    function automatic logic [AW-1:0] acc_add(input logic [AW-1:0] a);
        logic [AW:0] sum;
        sum = {1'b0, a} + INM_V;
        if (sum >= OUT_V) begin
            acc_add = AW'(sum - OUT_V);
        end else begin
            acc_add = AW'(sum);
        end
    endfunction

    assign acc_step_s = acc_add(acc_r);
    assign grant_id   = grant_r;
    assign busy       = (state_r != IDLE);

    // Round-robin search starting just after the previously granted source.
    always_comb begin
        pick_found_s = 1'b0;
        pick_idx_s   = '0;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (int'(last_r) + k) % N;
            if (!pick_found_s && req[idx] && (len[idx*LW +: LW] != '0)) begin
                pick_found_s = 1'b1;
                pick_idx_s   = GW'(idx);
            end else begin
                pick_found_s = pick_found_s;
            end
        end
    end

    // Next-state and combinational datapath outputs.
    always_comb begin
        state_nx = state_r;
        acc_nx   = acc_r;
        rem_nx   = rem_r;
        grant_nx = grant_r;
        last_nx  = last_r;
        m_val    = 1'b0;
        m_data   = '0;
        m_last   = 1'b0;
        m_pad    = 1'b0;
        s_rdy    = '0;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    grant_nx = pick_idx_s;
                    last_nx  = pick_idx_s;
                    rem_nx   = len[int'(pick_idx_s)*LW +: LW];
                    state_nx = DATA;
                end else begin
                    state_nx = IDLE;
                end
            end
            DATA: begin
                m_val          = s_val[grant_r];
                m_data         = s_data[int'(grant_r)*DW +: DW];
                s_rdy[grant_r] = m_rdy;
                m_last         = (rem_r == LW'(1)) && (acc_step_s == '0);
                if (s_val[grant_r] && m_rdy) begin
                    rem_nx = rem_r - LW'(1);
                    acc_nx = acc_step_s;
                    if (rem_r == LW'(1)) begin
                        state_nx = (acc_step_s == '0) ? IDLE : PAD;
                    end else begin
                        state_nx = DATA;
                    end
                end else begin
                    state_nx = DATA;
                end
            end
            PAD: begin
                m_val  = 1'b1;
                m_pad  = 1'b1;
                m_last = (acc_step_s == '0);
                if (m_rdy) begin
                    acc_nx   = acc_step_s;
                    state_nx = (acc_step_s == '0) ? IDLE : PAD;
                end else begin
                    state_nx = PAD;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and counter registers; last resets to N-1 so source 0 wins first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            acc_r   <= '0;
            rem_r   <= '0;
            grant_r <= '0;
            last_r  <= GW'(N - 1);
        end else begin
            state_r <= state_nx;
            acc_r   <= acc_nx;
            rem_r   <= rem_nx;
            grant_r <= grant_nx;
            last_r  <= last_nx;
        end
    end
endmodule

// File: tb/tb_chnl_pack_arb.sv
// Randomized bench for chnl_pack_arb against a burst-level reference model
// (grant order, data beats, pad count derived from the chunk arithmetic).
module tb_chnl_pack_arb;
    localparam int N  = 4;
    localparam int IN = 3;
    localparam int OUT = 8;
    localparam int W  = 8;
    localparam int LW = 16;
    localparam int DW = W * IN;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req;
    logic [N*LW-1:0]   len;
    logic [N-1:0]      s_val;
    logic [N-1:0]      s_rdy;
    logic [N*DW-1:0]   s_data;
    logic              m_val;
    logic              m_rdy;
    logic [DW-1:0]     m_data;
    logic              m_last;
    logic              m_pad;
    logic [1:0]        grant_id;
    logic              busy;

    int errors = 0;
    int checks = 0;

    int          lens [N];
    logic [DW-1:0] cur_data [N];
    int          rdy_mode;
    bit          sval_rand;

    // reference model state: whole-burst view
    bit mbusy;
    int mg, mdata_left, mpad_left, mlast;

    chnl_pack_arb #(.N(N), .IN(IN), .OUT(OUT), .W(W), .LW(LW)) dut (
        .clk(clk), .rst(rst), .req(req), .len(len), .s_val(s_val), .s_rdy(s_rdy),
        .s_data(s_data), .m_val(m_val), .m_rdy(m_rdy), .m_data(m_data),
        .m_last(m_last), .m_pad(m_pad), .grant_id(grant_id), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // smallest number of pad beats making total chunks a multiple of OUT
    function automatic int pads(input int l);
        int p = 0;
        while (((l + p) * IN) % OUT != 0) p++;
        return p;
    endfunction

    function automatic int pick(input int from);
        for (int k = 1; k <= N; k++) begin
            int idx = (from + k) % N;
            if (req[idx] && lens[idx] != 0) return idx;
        end
        return -1;
    endfunction

    task automatic set_len();
        for (int i = 0; i < N; i++) len[i*LW +: LW] = LW'(lens[i]);
    endtask

    task automatic model_reset();
        mbusy = 1'b0; mg = 0; mdata_left = 0; mpad_left = 0; mlast = N - 1;
    endtask

    task automatic check_outputs();
        if (!mbusy) begin
            chk("idle_busy", 64'(busy), 64'(0));
            chk("idle_mval", 64'(m_val), 64'(0));
            chk("idle_srdy", 64'(s_rdy), 64'(0));
        end else if (mdata_left > 0) begin
            chk("data_busy", 64'(busy), 64'(1));
            chk("data_gid", 64'(grant_id), 64'(mg));
            chk("data_mval", 64'(m_val), 64'(s_val[mg]));
            chk("data_srdy", 64'(s_rdy), 64'(m_rdy ? (1 << mg) : 0));
            if (s_val[mg]) begin
                chk("data_bytes", 64'(m_data), 64'(cur_data[mg]));
                chk("data_pad", 64'(m_pad), 64'(0));
                chk("data_last", 64'(m_last), 64'(mdata_left == 1 && mpad_left == 0));
            end
        end else begin
            chk("pad_busy", 64'(busy), 64'(1));
            chk("pad_gid", 64'(grant_id), 64'(mg));
            chk("pad_mval", 64'(m_val), 64'(1));
            chk("pad_flag", 64'(m_pad), 64'(1));
            chk("pad_zero", 64'(m_data), 64'(0));
            chk("pad_srdy", 64'(s_rdy), 64'(0));
            chk("pad_last", 64'(m_last), 64'(mpad_left == 1));
        end
    endtask

    task automatic model_edge();
        if (!mbusy) begin
            int p = pick(mlast);
            if (p >= 0) begin
                mbusy = 1'b1; mg = p; mlast = p;
                mdata_left = lens[p]; mpad_left = pads(lens[p]);
            end
        end else if (mdata_left > 0) begin
            if (s_val[mg] && m_rdy) begin
                cur_data[mg] = DW'($urandom);
                mdata_left--;
                if (mdata_left == 0 && mpad_left == 0) mbusy = 1'b0;
            end
        end else if (m_rdy) begin
            mpad_left--;
            if (mpad_left == 0) mbusy = 1'b0;
        end
    endtask

    // one cycle: drive after the edge, check at negedge, advance model at posedge
    task automatic step();
        case (rdy_mode)
            0: m_rdy = 1'b1;
            1: m_rdy = ~m_rdy;
            default: m_rdy = 1'($urandom_range(0, 1));
        endcase
        s_val = sval_rand ? N'($urandom) : '1;
        for (int i = 0; i < N; i++) s_data[i*DW +: DW] = cur_data[i];
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic run(input int cycles);
        for (int c = 0; c < cycles; c++) step();
    endtask

    task automatic drain();
        req = '0;
        for (int k = 0; k < 200 && mbusy; k++) step();
        chk("drain_timeout", 64'(mbusy), 64'(0));
    endtask

    initial begin
        rst = 1'b1; req = '0; len = '0; s_val = '0; m_rdy = 1'b0; s_data = '0;
        rdy_mode = 0; sval_rand = 1'b0;
        for (int i = 0; i < N; i++) begin lens[i] = 0; cur_data[i] = DW'($urandom); end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_mval", 64'(m_val), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_gid", 64'(grant_id), 64'(0));
        chk("rst_srdy", 64'(s_rdy), 64'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // two sources, len 8: no pad, source 0 then 2
        req = 4'b0101; lens = '{8, 0, 8, 0}; set_len();
        run(20); drain();

        // len 1 and len 2: 7 and 6 pad beats
        req = 4'b0010; lens = '{0, 1, 0, 0}; set_len();
        run(1); drain();
        req = 4'b1000; lens = '{0, 0, 0, 2}; set_len();
        run(1); drain();

        // zero-length request never granted
        req = 4'b0001; lens = '{0, 0, 0, 0}; set_len();
        run(10);
        chk("zero_len_busy", 64'(busy), 64'(0));

        // fairness with all requesters, len 1
        req = 4'b1111; lens = '{1, 1, 1, 1}; set_len();
        run(40); drain();

        // backpressure: toggling m_rdy, random s_val, len 3
        rdy_mode = 1; sval_rand = 1'b1;
        req = 4'b0100; lens = '{0, 0, 3, 0}; set_len();
        run(1); drain();

        // random mix of requests and lengths
        rdy_mode = 2;
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++) lens[i] = $urandom_range(0, 5);
            set_len();
            req = N'($urandom);
            run($urandom_range(1, 12));
        end
        drain();

        // reset in the middle of padding
        rdy_mode = 0; sval_rand = 1'b0;
        req = 4'b1000; lens = '{0, 0, 0, 1}; set_len();
        for (int k = 0; k < 20 && !(mbusy && mdata_left == 0 && mpad_left <= 4); k++) step();
        chk("reached_pad", 64'(mbusy && mdata_left == 0), 64'(1));
        chk("in_pad_mpad", 64'(m_pad), 64'(1));
        req = '0;
        rst = 1'b1;
        #2;
        chk("arst_mval", 64'(m_val), 64'(0));
        chk("arst_mlast", 64'(m_last), 64'(0));
        chk("arst_mpad", 64'(m_pad), 64'(0));
        chk("arst_srdy", 64'(s_rdy), 64'(0));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_gid", 64'(grant_id), 64'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        req = 4'b1111; lens = '{2, 2, 2, 2}; set_len();
        run(1);
        chk("post_rst_grant0", 64'(grant_id), 64'(0));
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
